// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the ID-stage hazard unit: mul/div tracker state
// encodings, the hard-wired zero register and the register dependency test.
package hazard_unit_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Does the instruction in ID read register r? $0 never creates a dependency.
    function automatic logic reg_dep(input logic [4:0] r,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       uses_rt);
        return (r != REG_ZERO) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

endpackage

// File: rtl/hazard_unit_md_tracker.sv
// Tracks the iterative mul/div unit: busy window after issue, one-cycle done
// pulse, and the destination register of the operation in flight.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   MD_IDLE | unit free, waiting for an issue strobe from EX
//   MD_BUSY | operation in flight, cnt counts down the remaining busy cycles
//   MD_DONE | result written this cycle; a new issue may chain directly
module hazard_unit_md_tracker
    import hazard_unit_pkg::*;
#(
    parameter int MD_LATENCY = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       md_issue,
    input  logic [4:0] issue_rd,
    output logic       md_busy,
    output logic       md_done,
    output logic [4:0] md_rd
);

    localparam int CNT_BITS = $clog2(MD_LATENCY);

    md_state_e           state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [4:0]          md_rd_q, md_rd_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            md_rd_q <= REG_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            md_rd_q <= md_rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        md_rd_d = md_rd_q;
        case (state_q)
            MD_IDLE, MD_DONE: begin
                if (md_issue) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_BITS'(MD_LATENCY - 1);
                    md_rd_d = issue_rd;
                end else begin
                    state_d = MD_IDLE;
                end
            end
            // A stray issue strobe while busy cannot happen legally and is dropped.
            MD_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = MD_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_BITS'(1);
                end
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    always_comb begin
        md_busy = (state_q == MD_BUSY);
        md_done = (state_q == MD_DONE);
        md_rd   = md_rd_q;
    end

endmodule

// File: rtl/hazard_unit.sv
// ID-stage hazard unit: load-use and mul/div interlocks, taken-branch flush
// priority, and a saturating count of stall cycles.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IF_ID_rs,
    input  logic [4:0]       IF_ID_rt,
    input  logic             IF_ID_uses_rt,
    input  logic             IF_ID_md,
    input  logic             ID_EX_mem_read,
    input  logic [4:0]       ID_EX_rt,
    input  logic             ID_EX_md,
    input  logic [4:0]       ID_EX_rd,
    input  logic             EX_branch_taken,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             md_busy,
    output logic             md_done,
    output logic [4:0]       md_rd,
    output logic [CNT_W-1:0] stall_cycles
);

    logic             load_stall, md_stall, stall;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    hazard_unit_md_tracker #(
        .MD_LATENCY(MD_LATENCY)
    ) u_md_tracker (
        .clk     (clk),
        .rst     (rst),
        .md_issue(ID_EX_md),
        .issue_rd(ID_EX_rd),
        .md_busy (md_busy),
        .md_done (md_done),
        .md_rd   (md_rd)
    );

    // In DONE the result is written first-half, so only BUSY holds dependents.
    always_comb begin
        load_stall = ID_EX_mem_read && reg_dep(ID_EX_rt, IF_ID_rs, IF_ID_rt, IF_ID_uses_rt);
        md_stall   = md_busy && (reg_dep(md_rd, IF_ID_rs, IF_ID_rt, IF_ID_uses_rt) || IF_ID_md);
        stall      = load_stall || md_stall;
    end

    always_comb begin
        pc_write    = 1'b1;
        IF_ID_write = 1'b1;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        if (EX_branch_taken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (stall) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && !EX_branch_taken && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: a cycle-level reference model queues the
// expected outputs for each driven cycle; a monitor compares on the falling edge.
module tb_hazard_unit;

    localparam int L     = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    IF_ID_rs = '0, IF_ID_rt = '0, ID_EX_rt = '0, ID_EX_rd = '0;
    logic          IF_ID_uses_rt = 1'b0, IF_ID_md = 1'b0, ID_EX_mem_read = 1'b0;
    logic          ID_EX_md = 1'b0, EX_branch_taken = 1'b0;
    logic          pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, md_busy, md_done;
    logic [4:0]    md_rd;
    logic [CW-1:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_unit #(.MD_LATENCY(L), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .IF_ID_uses_rt(IF_ID_uses_rt),
        .IF_ID_md(IF_ID_md), .ID_EX_mem_read(ID_EX_mem_read), .ID_EX_rt(ID_EX_rt),
        .ID_EX_md(ID_EX_md), .ID_EX_rd(ID_EX_rd), .EX_branch_taken(EX_branch_taken),
        .pc_write(pc_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
        .ID_EX_flush(ID_EX_flush), .md_busy(md_busy), .md_done(md_done),
        .md_rd(md_rd), .stall_cycles(stall_cycles)
    );

    typedef struct {
        int cyc;
        int pc_write, if_id_write, if_id_flush, id_ex_flush;
        int md_busy, md_done, md_rd, stall_cycles;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: mul/div tracked as "issued at cycle N", not as an FSM.
    int   cyc        = 0;
    int   issue_cyc  = -1000;
    int   m_rd       = 0;
    int   m_cnt      = 0;
    bit   model_ok   = 1'b0;

    function automatic bit dep(int r, int rs, int rt, bit urt);
        return (r != 0) && (r == rs || (urt && r == rt));
    endfunction

    task automatic step(bit r, int rs, int rt, bit urt, bit imd,
                        bit mr, int ert, bit emd, int erd, bit br);
        exp_t e;
        bit   busy, done, ld, mds, st;
        @(posedge clk);
        #1;
        rst = r; IF_ID_rs = 5'(rs); IF_ID_rt = 5'(rt); IF_ID_uses_rt = urt;
        IF_ID_md = imd; ID_EX_mem_read = mr; ID_EX_rt = 5'(ert);
        ID_EX_md = emd; ID_EX_rd = 5'(erd); EX_branch_taken = br;

        busy = (cyc > issue_cyc) && (cyc <= issue_cyc + L);
        done = (cyc == issue_cyc + L + 1);
        ld   = mr && dep(ert, rs, rt, urt);
        mds  = busy && (dep(m_rd, rs, rt, urt) || imd);
        st   = ld || mds;
        e.cyc          = cyc;
        e.pc_write     = (br || !st) ? 1 : 0;
        e.if_id_write  = (br || !st) ? 1 : 0;
        e.if_id_flush  = br ? 1 : 0;
        e.id_ex_flush  = (br || st) ? 1 : 0;
        e.md_busy      = busy ? 1 : 0;
        e.md_done      = done ? 1 : 0;
        e.md_rd        = m_rd;
        e.stall_cycles = m_cnt;
        if (model_ok) exp_q.push_back(e);

        if (r) begin
            issue_cyc = -1000; m_rd = 0; m_cnt = 0; model_ok = 1'b1;
        end else begin
            if (st && !br) m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
            if (emd && !busy) begin
                issue_cyc = cyc; m_rd = erd;
            end
        end
        cyc++;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(string nm, int c, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, c, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_write",     e.cyc, int'(pc_write),     e.pc_write);
                chk("IF_ID_write",  e.cyc, int'(IF_ID_write),  e.if_id_write);
                chk("IF_ID_flush",  e.cyc, int'(IF_ID_flush),  e.if_id_flush);
                chk("ID_EX_flush",  e.cyc, int'(ID_EX_flush),  e.id_ex_flush);
                chk("md_busy",      e.cyc, int'(md_busy),      e.md_busy);
                chk("md_done",      e.cyc, int'(md_done),      e.md_done);
                chk("md_rd",        e.cyc, int'(md_rd),        e.md_rd);
                chk("stall_cycles", e.cyc, int'(stall_cycles), e.stall_cycles);
            end
        end
    end

    initial begin : driver
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // load-use on rs, then the load moves to MEM
        step(0, 5, 0, 0, 0, 1, 5, 0, 0, 0);
        step(0, 5, 0, 0, 0, 0, 5, 0, 0, 0);
        // load to $0, and rt match with rt unused
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 1, 6, 0, 0, 1, 6, 0, 0, 0);
        step(0, 1, 6, 1, 0, 1, 6, 0, 0, 0);
        idle(1);

        // mul/div issue to r8, dependent instruction held in ID
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 8, 0);
        for (int i = 0; i < L + 2; i++) step(0, 8, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // back-to-back mul/div: structural stall, then reissue in DONE
        step(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        for (int i = 0; i < L; i++) step(0, 1, 2, 1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 2, 1, 0, 0, 0, 1, 10, 0);
        for (int i = 0; i < L + 2; i++) step(0, 10, 0, 0, 0, 0, 0, 0, 0, 0);

        // branch taken over a load-use stall
        step(0, 3, 0, 0, 0, 1, 3, 0, 0, 1);
        idle(1);

        // reset in the second busy cycle
        step(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        step(0, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < L + 2; i++) step(0, 7, 0, 0, 0, 0, 0, 0, 0, 0);

        // counter saturation
        for (int i = 0; i < CMAX + 4; i++) step(0, 2, 0, 0, 0, 1, 2, 0, 0, 0);
        idle(1);

        for (int i = 0; i < 500; i++) begin
            bit br, emd;
            br  = ($urandom_range(0, 7) == 0);
            emd = !br && ($urandom_range(0, 3) == 0);
            step(($urandom_range(0, 63) == 0),
                 $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom),
                 ($urandom_range(0, 3) == 0), 1'($urandom), $urandom_range(0, 7),
                 emd, $urandom_range(0, 7), br);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        if (checks < 12) begin
            errors++;
            $display("FAIL check_count actual=%0d required=12", checks);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
